// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// Produces h/v counters, registered sync/data-enable/strobes and a blanked,
// optionally bordered colour output, plus a look-ahead framebuffer address
// (next_pixel_x) for a line-doubling framebuffer.
module vga_timing_gen #(
    parameter int   CNT_W    = 10,
    parameter int   H_ACT    = 512,
    parameter int   H_FP     = 58,
    parameter int   H_SYNC   = 82,
    parameter int   H_TOTAL  = 682,
    parameter int   V_ACT    = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_TOTAL  = 524,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   IN_BITS  = 5,
    parameter int   OUT_BITS = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sync,
    input  logic                  border,
    input  logic [3*IN_BITS-1:0]  pixel,
    output logic                  vga_h,
    output logic                  vga_v,
    output logic [OUT_BITS-1:0]   vga_r,
    output logic [OUT_BITS-1:0]   vga_g,
    output logic [OUT_BITS-1:0]   vga_b,
    output logic                  vga_de,
    output logic                  frame_start,
    output logic                  line_start,
    output logic [CNT_W-1:0]      vga_hcounter,
    output logic [CNT_W-1:0]      vga_vcounter,
    output logic [CNT_W-1:0]      next_pixel_x
);

    // Parameter sanity: these guarantee the counters never overflow CNT_W
    // and that every timing window lies inside the line/frame.
    if (CNT_W < 2 || CNT_W > 30) begin : g_bad_cnt_w
        $error("vga_timing_gen: CNT_W must be in 2..30");
    end
    if (H_TOTAL <= H_ACT + H_FP + H_SYNC) begin : g_bad_h_total
        $error("vga_timing_gen: H_TOTAL must exceed H_ACT+H_FP+H_SYNC");
    end
    if (V_TOTAL <= V_ACT + V_FP + V_SYNC) begin : g_bad_v_total
        $error("vga_timing_gen: V_TOTAL must exceed V_ACT+V_FP+V_SYNC");
    end
    if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_width
        $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CNT_W bits");
    end
    if (OUT_BITS < 1 || OUT_BITS > IN_BITS) begin : g_bad_bits
        $error("vga_timing_gen: need 1 <= OUT_BITS <= IN_BITS");
    end
    if (H_ACT < 1 || V_ACT < 1) begin : g_bad_act
        $error("vga_timing_gen: active area must be non-empty");
    end

    // Counter-width copies of the timing landmarks
    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS   = CNT_W'(H_ACT);
    localparam logic [CNT_W-1:0] V_VIS   = CNT_W'(V_ACT);
    localparam logic [CNT_W-1:0] H_RIGHT = CNT_W'(H_ACT - 1);
    localparam logic [CNT_W-1:0] V_BOT   = CNT_W'(V_ACT - 1);
    localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_ACT + H_FP);
    localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_ACT + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_ACT + V_FP);
    localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_ACT + V_FP + V_SYNC);

    logic [CNT_W-1:0] h, v;
    logic [CNT_W-1:0] h_nxt, v_nxt;
    logic             hend, sel;
    logic             de_c, edge_c, hs_c;
    logic [OUT_BITS-1:0] r_c, g_c, b_c;
    logic             unused_pixel;

    // Low pixel bits below the output depth are intentionally dropped
    assign unused_pixel = ^pixel;

    assign vga_hcounter = h;
    assign vga_vcounter = v;

    // Next raster position and the framebuffer half that position reads from
    always_comb begin
        hend  = (h == H_LAST);
        h_nxt = (hend || sync) ? '0 : h + CNT_W'(1);
        v_nxt = v;
        if (sync)
            v_nxt = '0;
        else if (hend)
            v_nxt = (v == V_LAST) ? '0 : v + CNT_W'(1);
        // sel follows the parity of the line the next pixel belongs to
        sel = 1'b0;
        if (!sync)
            sel = hend ? ~v[0] : v[0];
        next_pixel_x = {sel, h_nxt[CNT_W-2:0]};
    end

    // Raster counters
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            h <= '0;
            v <= '0;
        end else begin
            h <= h_nxt;
            v <= v_nxt;
        end
    end

    // Decode of the current position and pixel into pin values
    always_comb begin
        de_c   = (h < H_VIS) && (v < V_VIS);
        edge_c = (h == '0) || (h == H_RIGHT) || (v == '0) || (v == V_BOT);
        hs_c   = (h >= HS_BEG) && (h < HS_END);
        r_c    = pixel[IN_BITS-1   -: OUT_BITS];
        g_c    = pixel[2*IN_BITS-1 -: OUT_BITS];
        b_c    = pixel[3*IN_BITS-1 -: OUT_BITS];
        // blanking wins over the border overlay
        if (!de_c) begin
            r_c = '0;
            g_c = '0;
            b_c = '0;
        end else if (border && edge_c) begin
            r_c = '1;
            g_c = '1;
            b_c = '1;
        end
    end

    // Output pin registers; reset and resync both park the pins inactive
    always_ff @(posedge clk) begin
        if (!reset_n || sync) begin
            vga_h       <= ~HS_POL;
            vga_v       <= ~VS_POL;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_de      <= 1'b0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            vga_h       <= hs_c ? HS_POL : ~HS_POL;
            // vsync only toggles at the hsync leading edge
            if (h == HS_BEG) begin
                if (v == VS_BEG)
                    vga_v <= VS_POL;
                else if (v == VS_END)
                    vga_v <= ~VS_POL;
            end
            vga_r       <= r_c;
            vga_g       <= g_c;
            vga_b       <= b_c;
            vga_de      <= de_c;
            line_start  <= (h == '0);
            frame_start <= (h == '0) && (v == '0);
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised bench for vga_timing_gen. Two instances share the stimulus:
// one with active-low syncs and 5->4 bit colour, one with active-high syncs
// and 6->3 bit colour. A small raster geometry keeps whole frames cheap.
// The reference model tracks a linear pixel position within the frame and
// derives every expected pin from it arithmetically.
module tb_vga_timing_gen;
    localparam int CW = 5;
    localparam int HA = 16, HF = 3, HS = 4, HT = 26;
    localparam int VA = 12, VF = 2, VS = 2, VT = 18;
    localparam int IA = 5, OA = 4, IB = 6, OB = 3;
    localparam int WA = 3 * IA, WB = 3 * IB;
    localparam int FRAME = HT * VT;
    localparam int VS_START = (VA + VF) * HT + HA + HF;
    localparam int VS_STOP  = (VA + VF + VS) * HT + HA + HF;

    logic clk = 1'b0;
    logic reset_n = 1'b0, sync = 1'b0, border = 1'b0;
    logic [WA-1:0] pix_a = '0;
    logic [WB-1:0] pix_b = '0;

    logic          h_a, v_a, de_a, fs_a, ls_a;
    logic [OA-1:0] r_a, g_a, b_a;
    logic [CW-1:0] hc_a, vc_a, npx_a;
    logic          h_b, v_b, de_b, fs_b, ls_b;
    logic [OB-1:0] r_b, g_b, b_b;
    logic [CW-1:0] hc_b, vc_b, npx_b;

    vga_timing_gen #(
        .CNT_W(CW), .H_ACT(HA), .H_FP(HF), .H_SYNC(HS), .H_TOTAL(HT),
        .V_ACT(VA), .V_FP(VF), .V_SYNC(VS), .V_TOTAL(VT),
        .HS_POL(1'b0), .VS_POL(1'b0), .IN_BITS(IA), .OUT_BITS(OA)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .sync(sync), .border(border),
        .pixel(pix_a), .vga_h(h_a), .vga_v(v_a),
        .vga_r(r_a), .vga_g(g_a), .vga_b(b_a), .vga_de(de_a),
        .frame_start(fs_a), .line_start(ls_a),
        .vga_hcounter(hc_a), .vga_vcounter(vc_a), .next_pixel_x(npx_a)
    );

    vga_timing_gen #(
        .CNT_W(CW), .H_ACT(HA), .H_FP(HF), .H_SYNC(HS), .H_TOTAL(HT),
        .V_ACT(VA), .V_FP(VF), .V_SYNC(VS), .V_TOTAL(VT),
        .HS_POL(1'b1), .VS_POL(1'b1), .IN_BITS(IB), .OUT_BITS(OB)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .sync(sync), .border(border),
        .pixel(pix_b), .vga_h(h_b), .vga_v(v_b),
        .vga_r(r_b), .vga_g(g_b), .vga_b(b_b), .vga_de(de_b),
        .frame_start(fs_b), .line_start(ls_b),
        .vga_hcounter(hc_b), .vga_vcounter(vc_b), .next_pixel_x(npx_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // model state: position of the pixel the DUT currently shows
    int mp = 0;
    bit have_exp = 1'b0;
    bit e_hs, e_vs, e_de, e_ls, e_fs;
    int e_ra, e_ga, e_ba, e_rb, e_gb, e_bb;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t pos=%0d)", tag, got, exp, $time, mp);
        end
    endtask

    function automatic int colour(input int pix, input int ib, input int ob,
                                  input int c, input bit de, input bit white);
        if (!de) return 0;
        if (white) return (1 << ob) - 1;
        return ((pix >> (c * ib)) & ((1 << ib) - 1)) >> (ib - ob);
    endfunction

    task automatic check_outs();
        chk("a_hsync", int'(h_a), int'(!e_hs));
        chk("b_hsync", int'(h_b), int'(e_hs));
        chk("a_vsync", int'(v_a), int'(!e_vs));
        chk("b_vsync", int'(v_b), int'(e_vs));
        chk("a_de", int'(de_a), int'(e_de));
        chk("b_de", int'(de_b), int'(e_de));
        chk("a_line_start", int'(ls_a), int'(e_ls));
        chk("b_line_start", int'(ls_b), int'(e_ls));
        chk("a_frame_start", int'(fs_a), int'(e_fs));
        chk("b_frame_start", int'(fs_b), int'(e_fs));
        chk("a_r", int'(r_a), e_ra);
        chk("a_g", int'(g_a), e_ga);
        chk("a_b", int'(b_a), e_ba);
        chk("b_r", int'(r_b), e_rb);
        chk("b_g", int'(g_b), e_gb);
        chk("b_b", int'(b_b), e_bb);
        chk("a_hcount", int'(hc_a), mp % HT);
        chk("a_vcount", int'(vc_a), mp / HT);
        chk("b_hcount", int'(hc_b), mp % HT);
        chk("b_vcount", int'(vc_b), mp / HT);
    endtask

    // One pixel clock: check the previous cycle's results, drive new inputs,
    // check the look-ahead address, then predict the next registered outputs.
    task automatic step(input bit rst, input bit sy, input bit brd);
        int  h, v, np, exp_npx;
        bit  hend, white;
        @(negedge clk);
        if (have_exp) check_outs();
        reset_n = !rst;
        sync    = sy;
        border  = brd;
        if ($urandom_range(3, 0) == 0) begin
            pix_a = '0;
            pix_b = '0;
        end else begin
            pix_a = WA'($urandom);
            pix_b = WB'($urandom);
        end
        #1;
        h = mp % HT;
        v = mp / HT;
        if (have_exp && !rst) begin
            hend = (h == HT - 1);
            np = sy ? 0 : (mp + 1) % FRAME;
            exp_npx = (np % HT) % (1 << (CW - 1));
            if (!sy) exp_npx += ((v + int'(hend)) % 2) << (CW - 1);
            chk("a_next_pixel_x", int'(npx_a), exp_npx);
            chk("b_next_pixel_x", int'(npx_b), exp_npx);
        end
        if (rst || sy) begin
            {e_hs, e_vs, e_de, e_ls, e_fs} = '0;
            {e_ra, e_ga, e_ba, e_rb, e_gb, e_bb} = '0;
            mp = 0;
        end else begin
            e_hs  = (h >= HA + HF) && (h < HA + HF + HS);
            e_vs  = (mp >= VS_START) && (mp < VS_STOP);
            e_de  = (h < HA) && (v < VA);
            e_ls  = (h == 0);
            e_fs  = (mp == 0);
            white = brd && (h == 0 || h == HA - 1 || v == 0 || v == VA - 1);
            e_ra  = colour(int'(pix_a), IA, OA, 0, e_de, white);
            e_ga  = colour(int'(pix_a), IA, OA, 1, e_de, white);
            e_ba  = colour(int'(pix_a), IA, OA, 2, e_de, white);
            e_rb  = colour(int'(pix_b), IB, OB, 0, e_de, white);
            e_gb  = colour(int'(pix_b), IB, OB, 1, e_de, white);
            e_bb  = colour(int'(pix_b), IB, OB, 2, e_de, white);
            mp    = (mp + 1) % FRAME;
        end
        have_exp = 1'b1;
    endtask

    // advance (bounded by one frame) until the model sits at position target
    task automatic seek(input int target);
        for (int k = 0; k < FRAME && mp != target; k++)
            step(1'b0, 1'b0, 1'(($urandom_range(1, 0))));
    endtask

    initial begin
        // reset, then several whole frames with random pixels/border
        repeat (3) step(1'b1, 1'b0, 1'b0);
        repeat (3 * FRAME) step(1'b0, 1'b0, 1'(($urandom_range(1, 0))));
        // mid-frame resync, then a full frame back to the origin
        seek(5 * HT + 10);
        step(1'b0, 1'b1, 1'b0);
        repeat (FRAME + 40) step(1'b0, 1'b0, 1'b1);
        // random resyncs and resets sprinkled over the raster
        repeat (2000)
            step(1'($urandom_range(699, 0) == 0), 1'($urandom_range(499, 0) == 0),
                 1'(($urandom_range(1, 0))));
        // reset asserted mid-line
        seek(7 * HT + 9);
        step(1'b1, 1'b0, 1'b1);
        repeat (HT + 5) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
